code_sequence_checker: RTL and testbench

Parametrised, clocked successor to the alarm's 4-digit key checker. Collects `CODE_LEN` symbols of `SYM_W` bits from the keypad/cable front end and compares them against a programmed code. It reports OK/ERROR/NOKEY/LOCKED, counts consecutive failures and enforces a timed lockout. An optional inter-symbol timeout is also supported. It sits between the input debouncer and the alarm control FSM.

---
 rtl/code_checker_pkg.sv | 21 ++
 rtl/cc_down_timer.sv | 34 +++
 rtl/code_sequence_checker.sv | 167 ++++++++++++++++
 tb/tb_code_sequence_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/code_checker_pkg.sv
// code_checker_pkg
//   Shared definitions for code_sequence_checker and its down timer:
//   status encoding, FSM state type and a counter width helper.
package code_checker_pkg;

    localparam logic [1:0] STAT_OK     = 2'd0;
    localparam logic [1:0] STAT_LOCKED = 2'd1;
    localparam logic [1:0] STAT_ERROR  = 2'd2;
    localparam logic [1:0] STAT_NOKEY  = 2'd3;

    typedef enum logic {
        ENTRY   = 1'b0,
        LOCKOUT = 1'b1
    } cc_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cc_down_timer.sv
// cc_down_timer
//   Loadable down counter that stops at zero.
//   Ports:
//     clk, reset (async, active-high)
//     load     : load load_val this cycle (wins over dec)
//     load_val : value to load
//     dec      : decrement by one, holds at zero
//     zero     : count is zero
module cc_down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/code_sequence_checker.sv
// code_sequence_checker
//   Collects CODE_LEN symbols and compares them against code_in, reporting
//   OK / ERROR / NOKEY / LOCKED. MAX_FAILS consecutive bad entries start a
//   lockout of LOCK_CYCLES cycles during which input is ignored.
//   Optional macro CODE_SEQUENCE_CHECKER_TIMEOUT_EN: a partial entry left
//   idle for TIMEOUT_CYCLES cycles is aborted as if clear were pulsed.
//   Ports:
//     clk, reset (async, active-high)
//     sym_valid, sym_in : one-cycle symbol strobe and value
//     code_in           : programmed code, symbol k at [k*SYM_W +: SYM_W]
//     clear             : abort current entry (wins over sym_valid)
//     status            : OK/LOCKED/ERROR/NOKEY
//     locked            : high during lockout
//     fail_count        : consecutive failed entries
//     sym_count         : symbols accepted in the current entry
module code_sequence_checker
    import code_checker_pkg::*;
#(
    parameter int SYM_W          = 2,
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                sym_valid,
    input  logic [SYM_W-1:0]                    sym_in,
    input  logic [SYM_W*CODE_LEN-1:0]           code_in,
    input  logic                                clear,
    output logic [1:0]                          status,
    output logic                                locked,
    output logic [$clog2(MAX_FAILS+1)-1:0]      fail_count,
    output logic [$clog2(CODE_LEN+1)-1:0]       sym_count
);

    localparam int FW = $clog2(MAX_FAILS+1);
    localparam int CW = $clog2(CODE_LEN+1);
    localparam int LW = cnt_width(LOCK_CYCLES);

    cc_state_e      state_q;
    logic [1:0]     status_q;
    logic           locked_q;
    logic [FW-1:0]  fail_q;
    logic [CW-1:0]  sym_cnt_q;
    logic           mismatch_q;

    logic [SYM_W-1:0] code_sym;
    logic             in_entry;
    logic             accept;
    logic             last_sym;
    logic             entry_bad;
    logic             lock_trip;
    logic             lock_zero;
    logic             timeout;
    logic             abort;

    // Code symbol expected at the current position, taken from the live
    // code_in so a reprogram only affects symbols not yet accepted.
    always_comb begin
        code_sym = code_in[SYM_W-1:0];
        for (int k = 0; k < CODE_LEN; k++) begin
            if (sym_cnt_q == CW'(k)) code_sym = code_in[k*SYM_W +: SYM_W];
        end
    end

    assign in_entry  = (state_q == ENTRY);
    assign accept    = in_entry && sym_valid && !clear;
    assign last_sym  = (sym_cnt_q == CW'(CODE_LEN-1));
    assign entry_bad = mismatch_q || (sym_in != code_sym);
    // The entry that would show the MAX_FAILS-th ERROR goes straight to LOCKED.
    assign lock_trip = accept && last_sym && entry_bad && (fail_q == FW'(MAX_FAILS-1));
    assign abort     = in_entry && (clear || timeout);

    // Loaded with LOCK_CYCLES-1 and exits on the cycle it reads zero, so the
    // lockout spans exactly LOCK_CYCLES cycles.
    cc_down_timer #(.W(LW)) u_lock_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (lock_trip),
        .load_val (LW'(LOCK_CYCLES-1)),
        .dec      (state_q == LOCKOUT),
        .zero     (lock_zero)
    );

`ifdef CODE_SEQUENCE_CHECKER_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    logic idle_tick;
    logic idle_zero;

    // An idle cycle is one inside a partial entry with no symbol and no clear.
    assign idle_tick = in_entry && (sym_cnt_q != '0) && !sym_valid && !clear;
    assign timeout   = idle_tick && idle_zero;

    cc_down_timer #(.W(TW)) u_idle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (TW'(TIMEOUT_CYCLES-1)),
        .dec      (idle_tick),
        .zero     (idle_zero)
    );
`else
    // No idle supervision in this build; partial entries wait forever.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ENTRY;
            status_q   <= STAT_NOKEY;
            locked_q   <= 1'b0;
            fail_q     <= '0;
            sym_cnt_q  <= '0;
            mismatch_q <= 1'b0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (abort) begin
                        sym_cnt_q  <= '0;
                        mismatch_q <= 1'b0;
                        status_q   <= STAT_NOKEY;
                    end else if (accept) begin
                        if (last_sym) begin
                            sym_cnt_q  <= '0;
                            mismatch_q <= 1'b0;
                            if (!entry_bad) begin
                                status_q <= STAT_OK;
                                fail_q   <= '0;
                            end else if (lock_trip) begin
                                state_q  <= LOCKOUT;
                                status_q <= STAT_LOCKED;
                                locked_q <= 1'b1;
                                fail_q   <= FW'(MAX_FAILS);
                            end else begin
                                status_q <= STAT_ERROR;
                                fail_q   <= fail_q + 1'b1;
                            end
                        end else begin
                            sym_cnt_q  <= sym_cnt_q + 1'b1;
                            mismatch_q <= entry_bad;
                            status_q   <= STAT_NOKEY;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_zero) begin
                        state_q   <= ENTRY;
                        status_q  <= STAT_NOKEY;
                        locked_q  <= 1'b0;
                        fail_q    <= '0;
                        sym_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    assign status     = status_q;
    assign locked     = locked_q;
    assign fail_count = fail_q;
    assign sym_count  = sym_cnt_q;

endmodule

// File: tb/tb_code_sequence_checker.sv
module tb_code_sequence_checker;

    localparam int SYM_W          = 2;
    localparam int CODE_LEN       = 4;
    localparam int MAX_FAILS      = 3;
    localparam int LOCK_CYCLES    = 20;
    localparam int TIMEOUT_CYCLES = 10;
    localparam int FW = $clog2(MAX_FAILS+1);
    localparam int CW = $clog2(CODE_LEN+1);

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      sym_valid = 1'b0;
    logic [SYM_W-1:0]          sym_in = '0;
    logic [SYM_W*CODE_LEN-1:0] code_in = 8'b00_11_10_01;
    logic                      clear = 1'b0;
    logic [1:0]                status;
    logic                      locked;
    logic [FW-1:0]             fail_count;
    logic [CW-1:0]             sym_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    code_sequence_checker #(
        .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS),
        .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_in(sym_in),
        .code_in(code_in), .clear(clear), .status(status), .locked(locked),
        .fail_count(fail_count), .sym_count(sym_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Status codes: 0 OK, 1 LOCKED, 2 ERROR, 3 NOKEY.
    int m_status = 3, m_fail = 0, m_lock_left = 0, m_idle = 0;
    bit m_locked = 0;
    bit m_hits[$];   // per-symbol match results of the current entry
    bit m_good;

    task automatic m_abort();
        m_hits.delete();
        m_status = 3;
        m_idle   = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            m_status = 3; m_fail = 0; m_lock_left = 0; m_locked = 0; m_idle = 0;
            m_hits.delete();
        end else if (m_locked) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_locked = 0; m_fail = 0; m_status = 3; m_hits.delete();
            end
        end else if (clear) begin
            m_abort();
        end else if (sym_valid) begin
            m_hits.push_back(sym_in == code_in[m_hits.size()*SYM_W +: SYM_W]);
            m_idle = 0;
            if (m_hits.size() == CODE_LEN) begin
                m_good = 1;
                foreach (m_hits[i]) if (!m_hits[i]) m_good = 0;
                m_hits.delete();
                if (m_good) begin
                    m_status = 0; m_fail = 0;
                end else if (m_fail + 1 >= MAX_FAILS) begin
                    m_fail = MAX_FAILS; m_status = 1; m_locked = 1; m_lock_left = LOCK_CYCLES;
                end else begin
                    m_fail++; m_status = 2;
                end
            end else begin
                m_status = 3;
            end
        end else if (m_hits.size() > 0) begin
`ifdef CODE_SEQUENCE_CHECKER_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT_CYCLES) m_abort();
`endif
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("status",     status,     m_status);
            chk("locked",     locked,     m_locked);
            chk("fail_count", fail_count, m_fail);
            chk("sym_count",  sym_count,  m_hits.size());
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [SYM_W-1:0] s);
        sym_valid = 1'b1;
        sym_in    = s;
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic send_code(input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] c, input logic [1:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic lit(input string nm, input int st, input int lk, input int fc, input int sc);
        chk({nm, ".status"},     status,     st);
        chk({nm, ".locked"},     locked,     lk);
        chk({nm, ".fail_count"}, fail_count, fc);
        chk({nm, ".sym_count"},  sym_count,  sc);
    endtask

    task automatic async_reset(input string nm);
        #2 reset = 1'b1;
        #1 lit(nm, 3, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit("reset", 3, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);

        // correct entry
        send_code(2'b01, 2'b10, 2'b11, 2'b00);
        lit("correct", 0, 0, 0, 0);

        // single error then recovery
        send_code(2'b01, 2'b10, 2'b00, 2'b00);
        lit("single_err", 2, 0, 1, 0);
        send_code(2'b01, 2'b10, 2'b11, 2'b00);
        lit("recover", 0, 0, 0, 0);

        // lockout with ignored strobes
        send_code(2'b00, 2'b00, 2'b00, 2'b00);
        lit("fail1", 2, 0, 1, 0);
        send_code(2'b00, 2'b00, 2'b00, 2'b00);
        lit("fail2", 2, 0, 2, 0);
        send_code(2'b00, 2'b00, 2'b00, 2'b00);
        lit("lock", 1, 1, 3, 0);
        for (int k = 1; k < LOCK_CYCLES; k++) begin
            sym_valid = k[0];
            sym_in    = 2'b01;
            clear     = (k == 6);
            @(negedge clk);
            chk("lock_hold", locked, 1);
        end
        sym_valid = 1'b0;
        clear     = 1'b0;
        @(negedge clk);
        lit("unlock", 3, 0, 0, 0);

        // clear wins over simultaneous symbol; fail_count kept
        send_code(2'b11, 2'b11, 2'b11, 2'b11);
        send(2'b01); send(2'b10);
        chk("pre_clear.sym_count", sym_count, 2);
        sym_valid = 1'b1; clear = 1'b1; sym_in = 2'b11;
        @(negedge clk);
        sym_valid = 1'b0; clear = 1'b0;
        lit("clear", 3, 0, 1, 0);
        send_code(2'b01, 2'b10, 2'b11, 2'b00);
        lit("after_clear", 0, 0, 0, 0);

        // async reset mid-entry and mid-lockout
        send(2'b01); send(2'b10); send(2'b11);
        chk("mid.sym_count", sym_count, 3);
        async_reset("rst_entry");
        repeat (3) send_code(2'b10, 2'b10, 2'b10, 2'b10);
        chk("pre_rst.locked", locked, 1);
        repeat (5) @(negedge clk);
        async_reset("rst_lock");

        // idle behaviour
        send_code(2'b00, 2'b00, 2'b00, 2'b00);
        send(2'b01); send(2'b10);
        repeat (TIMEOUT_CYCLES-1) @(negedge clk);
        chk("idle9.sym_count", sym_count, 2);
        @(negedge clk);
`ifdef CODE_SEQUENCE_CHECKER_TIMEOUT_EN
        lit("timeout", 3, 0, 1, 0);
        repeat (40) @(negedge clk);
        send_code(2'b01, 2'b10, 2'b11, 2'b00);
`else
        lit("no_timeout", 3, 0, 1, 2);
        repeat (40) @(negedge clk);
        chk("idle50.sym_count", sym_count, 2);
        send(2'b11); send(2'b00);
`endif
        lit("idle_done", 0, 0, 0, 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            sym_valid = ($urandom_range(0, 2) != 0) || (c % 400 > 300 && $urandom_range(0, 9) == 0);
            if (c % 400 > 300) sym_valid = ($urandom_range(0, 19) == 0);
            sym_in = ($urandom_range(0, 4) != 0) ?
                     code_in[(m_hits.size() % CODE_LEN)*SYM_W +: SYM_W] : SYM_W'($urandom);
            clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) code_in = (SYM_W*CODE_LEN)'($urandom);
            if (c == 2500) begin
                sym_valid = 1'b0; clear = 1'b0;
                async_reset("rst_rand");
            end else begin
                @(negedge clk);
            end
        end
        sym_valid = 1'b0;
        clear     = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
